pwm_multi_shadow: RTL and testbench
===================================

// Module: pwm_multi_shadow
// PURPOSE
//  Multi-channel PWM generator with one shared period counter, per-channel duty and polarity,
//  and selectable edge- or center-aligned mode. New period/duty/polarity/mode values are staged
//  and applied only at a period boundary, so no output sees a truncated or glitched pulse.
//  Drives motor/LED/power stages; period_end lets downstream logic (ADC trigger, DMA) sync to PWM.
// PARAMETERS
//  WIDTH     16  counter, period and duty width in bits
//  CHANNELS   4  number of PWM outputs sharing the counter
// PORTS
//  clk          in   1               system clock
//  rst_n        in   1               synchronous active-low reset
//  enable       in   1               1 = run counter; 0 = idle (counter held at 0)
//  load         in   1               1-cycle strobe: capture period/duty/polarity/center_mode into staging
//  period       in   WIDTH           edge: period in clk cycles; center: half-period in clk cycles
//  duty         in   CHANNELS*WIDTH  channel i duty at [i*WIDTH +: WIDTH]
//  polarity     in   CHANNELS        1 = invert channel i output
//  center_mode  in   1               0 = edge-aligned, 1 = center-aligned
//  pwm_out      out  CHANNELS        registered PWM outputs
//  period_end   out  1               registered 1-cycle pulse on last cycle of each period
//  busy_pending out  1               staged values waiting for next boundary
// BEHAVIOUR
//  - Reset: counter=0, dir=up, active and staging period/duty/polarity/mode=0, pending=0,
//    pwm_out=0, period_end=0, busy_pending=0.
//  - Registers: staging (written by load) -> active (used by counter/compare).
//  - Boundary: a cycle with enable=1, active period>=1, and counter at final value
//    (edge: cnt==P-1; center: dir=down and cnt==0). Also a boundary: enable=0 or active period==0.
//  - load: staging<=inputs, pending<=1. Repeated loads before a boundary overwrite staging.
//  - At a boundary with pending=1: active<=staging, pending<=0, counter<=0, dir<=up.
//    A load on a boundary cycle bypasses staging: its inputs go straight to active.
//  - Edge mode: cnt 0,1,...,P-1,0,... ; raw_i = (cnt < duty_i). Period = P cycles.
//  - Center mode: cnt up 0..P-1, then down P-1..0, with dir flipping at each end.
//    raw_i = (cnt < duty_i). Period = 2P cycles; high time = 2*duty_i, centred on cnt==0.
//  - pwm_out[i] <= raw_i ^ pol_i (one clk after counter state). period_end <= boundary condition
//    with enable=1 and P>=1.
//  - Width and boundary rules:
//    * Compares are unsigned, WIDTH bits. P-1 is computed only when P>=1.
//    * duty_i==0: constant inactive level. duty_i>=P: constant active level (100%).
//    * P==1 edge: cnt stays 0, period_end high every cycle.
//    * P==1 center: cnt stays 0, dir toggles, period_end every 2nd cycle.
//    * P==0: counter held at 0, raw=0, pwm_out=polarity, period_end=0.
//  - enable=0: counter=0, dir=up, raw=0, pwm_out=polarity, period_end=0.
//    Staging still applies (idle is a boundary). On enable 0->1, counting starts at cnt=0.
//  - rst_n low mid-period: all state back to reset values on that edge. Staging is discarded.
// TESTING
//  1. Edge, load P=10, duty0=3, pol=0, enable=1 -> pwm_out[0] high 3 / low 7 clk.
//     period_end every 10 clk.
//  2. Center, P=8, duty1=2 -> pwm_out[1] high 4 clk centred on cnt==0, period 16 clk.
//     period_end once per 16.
//  3. Mid-period load duty0=7 at cnt=4 (P=10, duty0=3) -> current period unchanged,
//     busy_pending=1. Next period high 7 clk.
//  4. Corners, P=10: duty=0 -> constant 0. duty=10 and duty=65535 -> constant 1. pol=1 inverts both.
//     P=0 -> pwm_out==polarity, no period_end.
//  5. Two loads before boundary (duty 5 then 6) -> only 6 takes effect.
//     Load exactly on boundary cycle -> new value active in the immediately following period.
//  6. rst_n low for 1 clk at cnt=5 with pending=1 -> all outputs 0, counter 0, pending 0.
//     Old values are not applied.

Source files
------------

// File: rtl/pwm_multi_shadow_if.sv
// Configuration and status bundle for the multi-channel shadowed PWM.
// The controller drives the configuration side and the PWM block drives the outputs.
interface pwm_multi_shadow_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic                      enable;
    logic                      load;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS-1:0]       polarity;
    logic                      center_mode;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_end;
    logic                      busy_pending;

    modport master (
        output enable, load, period, duty, polarity, center_mode,
        input  pwm_out, period_end, busy_pending
    );

    modport slave (
        input  enable, load, period, duty, polarity, center_mode,
        output pwm_out, period_end, busy_pending
    );
endinterface

// File: rtl/pwm_multi_shadow.sv
// Multi-channel PWM with one shared up/up-down counter.
// Configuration is staged on load and only becomes active at a period boundary,
// so a running output never sees a truncated or glitched pulse.

// One PWM lane: compare the shared counter against this lane's duty.
module pwm_multi_shadow_chan #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    input  logic             pol,
    output logic             pwm_out
);
    // Registered compare; when idle the lane rests at its inactive (polarity) level.
    always_ff @(posedge clk) begin
        if (!rst_n) pwm_out <= 1'b0;
        else        pwm_out <= (run && (cnt < duty)) ^ pol;
    end
endmodule

module pwm_multi_shadow #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic clk,
    input  logic rst_n,
    pwm_multi_shadow_if.slave bus
);
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    typedef struct packed {
        logic [WIDTH-1:0]                period;
        logic [CHANNELS-1:0][WIDTH-1:0]  duty;
        logic [CHANNELS-1:0]             pol;
        logic                            center;
    } cfg_t;

    cfg_t                act_q, act_n, stg_q, stg_n, cfg_in;
    logic                pend_q, pend_n;
    logic [WIDTH-1:0]    cnt, cnt_n, pm1;
    dir_e                dir_q, dir_n;
    logic                run, at_end, boundary, pe_q;
    logic [CHANNELS-1:0] pwm_q;

    assign cfg_in.period = bus.period;
    assign cfg_in.duty   = bus.duty;
    assign cfg_in.pol    = bus.polarity;
    assign cfg_in.center = bus.center_mode;

    // Counting only happens with a nonzero period; anything else is an idle boundary.
    assign run      = bus.enable && (act_q.period != '0);
    assign pm1      = act_q.period - WIDTH'(1);
    assign at_end   = run && (act_q.center ? (dir_q == DIR_DOWN && cnt == '0) : (cnt == pm1));
    assign boundary = !run || at_end;

    // Next-state: shadow register handover and counter/direction sequencing.
    always_comb begin
        act_n  = act_q;
        stg_n  = stg_q;
        pend_n = pend_q;
        cnt_n  = cnt;
        dir_n  = dir_q;

        // A load landing on a boundary is the newest value, so it wins over staging.
        if (bus.load) begin
            stg_n = cfg_in;
            if (boundary) begin
                act_n  = cfg_in;
                pend_n = 1'b0;
            end else begin
                pend_n = 1'b1;
            end
        end else if (boundary && pend_q) begin
            act_n  = stg_q;
            pend_n = 1'b0;
        end

        if (boundary) begin
            cnt_n = '0;
            dir_n = DIR_UP;
        end else if (!act_q.center) begin
            cnt_n = cnt + WIDTH'(1);
        end else if (dir_q == DIR_UP) begin
            // Top of the triangle: hold the count one extra cycle while turning around.
            if (cnt == pm1) dir_n = DIR_DOWN;
            else            cnt_n = cnt + WIDTH'(1);
        end else begin
            cnt_n = cnt - WIDTH'(1);
        end
    end

    // State registers; reset also discards anything staged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q  <= '0;
            stg_q  <= '0;
            pend_q <= 1'b0;
            cnt    <= '0;
            dir_q  <= DIR_UP;
            pe_q   <= 1'b0;
        end else begin
            act_q  <= act_n;
            stg_q  <= stg_n;
            pend_q <= pend_n;
            cnt    <= cnt_n;
            dir_q  <= dir_n;
            pe_q   <= at_end;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pwm_multi_shadow_chan #(.WIDTH(WIDTH)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .run     (run),
            .cnt     (cnt),
            .duty    (act_q.duty[g]),
            .pol     (act_q.pol[g]),
            .pwm_out (pwm_q[g])
        );
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_end   = pe_q;
    assign bus.busy_pending = pend_q;
endmodule

// File: tb/tb_pwm_multi_shadow.sv
// Directed bench for pwm_multi_shadow: edge/center waveforms, shadow handover,
// duty/period corners and mid-period reset.
module tb_pwm_multi_shadow;
    localparam int W = 16;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Per-sample captures from run_period: bit i = i-th sampled cycle.
    logic [63:0] ch_v [C];
    logic [63:0] pe_v;
    logic [63:0] bp_v;

    pwm_multi_shadow_if #(.WIDTH(W), .CHANNELS(C)) bus ();

    pwm_multi_shadow #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Wait (bounded) until a sampled period_end; returns on that negedge.
    task automatic wait_pe();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.period_end === 1'b1) break;
        end
        n_checks++;
        if (k == 100) begin
            n_fail++;
            $display("FAIL wait_pe: period_end got none want pulse within 100 clk");
        end
    endtask

    // Capture n samples; optionally pulse load with a new duty0 at samples la / lb.
    task automatic run_period(input int n, input int la, input int da, input int lb, input int db);
        for (int c = 0; c < C; c++) ch_v[c] = '0;
        pe_v = '0;
        bp_v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int c = 0; c < C; c++) ch_v[c][i] = bus.pwm_out[c];
            pe_v[i] = bus.period_end;
            bp_v[i] = bus.busy_pending;
            bus.load = 1'b0;
            if (i == la) begin bus.duty[W-1:0] = W'(da); bus.load = 1'b1; end
            if (i == lb) begin bus.duty[W-1:0] = W'(db); bus.load = 1'b1; end
        end
    endtask

    // Idle, load a config directly into active (idle is a boundary), then run.
    task automatic setup(input logic [W-1:0] p, input logic [C*W-1:0] d,
                         input logic [C-1:0] pol, input logic cm, input logic do_wait);
        @(negedge clk);
        bus.enable      = 1'b0;
        bus.period      = p;
        bus.duty        = d;
        bus.polarity    = pol;
        bus.center_mode = cm;
        bus.load        = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        if (do_wait) wait_pe();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.load = 1'b0; bus.period = '0;
        bus.duty = '0; bus.polarity = '0; bus.center_mode = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.pwm_out !== 4'b0000 || bus.period_end !== 1'b0 || bus.busy_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got pwm=%b pe=%b bp=%b want 0000 0 0",
                     bus.pwm_out, bus.period_end, bus.busy_pending);
        end
        n_checks++;
        if (dut.cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", dut.cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_edge();
        setup(16'd10, {48'd0, 16'd3}, 4'b0000, 1'b0, 1'b1);
        run_period(10, -1, 0, -1, 0);
        n_checks++;
        if (ch_v[0][9:0] !== 10'b00_0000_0111) begin
            n_fail++; $display("FAIL edge_pwm0: got %b want %b", ch_v[0][9:0], 10'b0000000111);
        end
        n_checks++;
        if (pe_v[9:0] !== 10'b10_0000_0000) begin
            n_fail++; $display("FAIL edge_pe: got %b want %b", pe_v[9:0], 10'b1000000000);
        end
    endtask

    task automatic test_center();
        setup(16'd8, {32'd0, 16'd2, 16'd0}, 4'b0000, 1'b1, 1'b1);
        run_period(16, -1, 0, -1, 0);
        n_checks++;
        if (ch_v[1][15:0] !== 16'hC003) begin
            n_fail++; $display("FAIL center_pwm1: got %h want c003", ch_v[1][15:0]);
        end
        n_checks++;
        if (pe_v[15:0] !== 16'h8000) begin
            n_fail++; $display("FAIL center_pe: got %h want 8000", pe_v[15:0]);
        end
    endtask

    task automatic test_mid_load();
        setup(16'd10, {48'd0, 16'd3}, 4'b0000, 1'b0, 1'b1);
        run_period(10, 3, 7, -1, 0);   // load lands while cnt==4
        n_checks++;
        if (ch_v[0][9:0] !== 10'b00_0000_0111) begin
            n_fail++; $display("FAIL mid_cur_pwm0: got %b want 0000000111", ch_v[0][9:0]);
        end
        n_checks++;
        if (bp_v[9:0] !== 10'b01_1111_0000) begin
            n_fail++; $display("FAIL mid_pending: got %b want 0111110000", bp_v[9:0]);
        end
        run_period(10, -1, 0, -1, 0);
        n_checks++;
        if (ch_v[0][9:0] !== 10'b00_0111_1111) begin
            n_fail++; $display("FAIL mid_next_pwm0: got %b want 0001111111", ch_v[0][9:0]);
        end
    endtask

    task automatic test_back_to_back();
        run_period(10, 1, 5, 3, 6);
        n_checks++;
        if (ch_v[0][9:0] !== 10'b00_0111_1111 || bp_v[9:0] !== 10'b01_1111_1100) begin
            n_fail++; $display("FAIL b2b_cur: got pwm=%b bp=%b want 0001111111 0111111100",
                               ch_v[0][9:0], bp_v[9:0]);
        end
        run_period(10, 8, 2, -1, 0);   // second load lands on the boundary cycle
        n_checks++;
        if (ch_v[0][9:0] !== 10'b00_0011_1111) begin
            n_fail++; $display("FAIL b2b_last_wins: got %b want 0000111111", ch_v[0][9:0]);
        end
        n_checks++;
        if (bp_v[9:0] !== 10'd0 || pe_v[9:0] !== 10'b10_0000_0000) begin
            n_fail++; $display("FAIL b2b_bypass_flags: got bp=%b pe=%b want 0000000000 1000000000",
                               bp_v[9:0], pe_v[9:0]);
        end
        run_period(10, -1, 0, -1, 0);
        n_checks++;
        if (ch_v[0][9:0] !== 10'b00_0000_0011) begin
            n_fail++; $display("FAIL b2b_boundary_load: got %b want 0000000011", ch_v[0][9:0]);
        end
    endtask

    task automatic test_corners();
        setup(16'd10, {16'd3, 16'd65535, 16'd10, 16'd0}, 4'b0000, 1'b0, 1'b1);
        run_period(10, -1, 0, -1, 0);
        n_checks++;
        if (ch_v[0][9:0] !== 10'h000 || ch_v[1][9:0] !== 10'h3FF ||
            ch_v[2][9:0] !== 10'h3FF || ch_v[3][9:0] !== 10'h007) begin
            n_fail++; $display("FAIL corner_duty: got %h %h %h %h want 000 3ff 3ff 007",
                               ch_v[0][9:0], ch_v[1][9:0], ch_v[2][9:0], ch_v[3][9:0]);
        end
        setup(16'd10, {16'd3, 16'd65535, 16'd10, 16'd0}, 4'b0111, 1'b0, 1'b1);
        run_period(10, -1, 0, -1, 0);
        n_checks++;
        if (ch_v[0][9:0] !== 10'h3FF || ch_v[1][9:0] !== 10'h000 ||
            ch_v[2][9:0] !== 10'h000 || ch_v[3][9:0] !== 10'h007) begin
            n_fail++; $display("FAIL corner_pol: got %h %h %h %h want 3ff 000 000 007",
                               ch_v[0][9:0], ch_v[1][9:0], ch_v[2][9:0], ch_v[3][9:0]);
        end
        setup(16'd0, {16'd3, 16'd65535, 16'd10, 16'd0}, 4'b1010, 1'b0, 1'b0);
        run_period(20, -1, 0, -1, 0);
        n_checks++;
        if (ch_v[0][19:0] !== 20'h0 || ch_v[1][19:0] !== 20'hFFFFF ||
            ch_v[2][19:0] !== 20'h0 || ch_v[3][19:0] !== 20'hFFFFF) begin
            n_fail++; $display("FAIL corner_p0_pwm: got %h %h %h %h want 00000 fffff 00000 fffff",
                               ch_v[0][19:0], ch_v[1][19:0], ch_v[2][19:0], ch_v[3][19:0]);
        end
        n_checks++;
        if (pe_v[19:0] !== 20'h0) begin
            n_fail++; $display("FAIL corner_p0_pe: got %h want 00000", pe_v[19:0]);
        end
    endtask

    task automatic test_mid_reset();
        setup(16'd10, {48'd0, 16'd3}, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.load = 1'b0;
            if (i == 1) begin bus.duty[W-1:0] = 16'd7; bus.load = 1'b1; end
            if (i == 4) rst_n = 1'b0;   // state cnt==5 here
        end
        n_checks++;
        if (bus.busy_pending !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_pending: got %b want 1", bus.busy_pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (bus.pwm_out !== 4'b0000 || bus.period_end !== 1'b0 ||
            bus.busy_pending !== 1'b0 || dut.cnt !== 16'd0) begin
            n_fail++; $display("FAIL rst_mid: got pwm=%b pe=%b bp=%b cnt=%0d want 0000 0 0 0",
                               bus.pwm_out, bus.period_end, bus.busy_pending, dut.cnt);
        end
        run_period(12, -1, 0, -1, 0);
        n_checks++;
        if (ch_v[0][11:0] !== 12'h0 || pe_v[11:0] !== 12'h0 || bp_v[11:0] !== 12'h0) begin
            n_fail++; $display("FAIL rst_no_old_cfg: got pwm0=%h pe=%h bp=%h want 000 000 000",
                               ch_v[0][11:0], pe_v[11:0], bp_v[11:0]);
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_mid_load();
        test_back_to_back();
        test_corners();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
